// File: rtl/div_seq.sv
// Iterative unsigned restoring divider built around one add_sub instance.
// One quotient bit is resolved per clock; start/busy/done handshake.

// N-bit adder/subtractor: ctrl = 1 computes a - b, cout = 1 means no borrow.
module add_sub #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ctrl,
    output logic [N-1:0] result,
    output logic         cout
);

    logic [N:0] sum;
    logic [N-1:0] b_eff;

    // Two's-complement subtract by inverting b and injecting a carry-in
    always_comb begin
        b_eff  = ctrl ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, ctrl};
        result = sum[N-1:0];
        cout   = sum[N];
    end

endmodule

module div_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0]  work_q;
    logic [N-1:0]  work_r;
    logic [N-1:0]  div_d;
    logic [CW-1:0] count;

    logic [N-1:0]  shifted;
    logic [N-1:0]  diff;
    logic          no_borrow;
    logic [N-1:0]  r_next;
    logic [N-1:0]  q_next;
    logic          last_iter;

    // Shift the next dividend bit into the partial remainder; R < 2^(N-1) so it fits
    always_comb begin
        shifted   = {work_r[N-2:0], work_q[N-1]};
        r_next    = no_borrow ? diff : shifted;
        q_next    = {work_q[N-2:0], no_borrow};
        last_iter = (count == CW'(N - 1));
    end

    add_sub #(.N(N)) u_add_sub (
        .a      (shifted),
        .b      (div_d),
        .ctrl   (1'b1),
        .result (diff),
        .cout   (no_borrow)
    );

    // Next-state logic: accept in IDLE, iterate N times, one DONE cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus registered busy/done so both come straight from flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
        end
    end

    // Working registers and result capture on the completing edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q      <= '0;
            work_r      <= '0;
            div_d       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_d  <= divisor;
                        work_q <= dividend;
                        work_r <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    work_r <= r_next;
                    work_q <= q_next;
                    count  <= count + CW'(1);
                    if (last_iter) begin
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= (div_d == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq (N = 8) with a result scoreboard.
module tb_div_seq;

    localparam int N = 8;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
    } result_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    result_t expQueue[$];
    int checkCount = 0;
    int failCount = 0;
    int doneCount = 0;
    logic prevDone = 1'b0;

    div_seq #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // 10-unit clock, rising edges at 5, 15, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference model using native divide and modulo, with divide-by-zero handled explicitly
    function automatic result_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        result_t res;
        if (b == 0) begin
            res.q  = '1;
            res.r  = a;
            res.dz = 1'b1;
        end else begin
            res.q  = a / b;
            res.r  = a % b;
            res.dz = 1'b0;
        end
        return res;
    endfunction

    // Scoreboard: pop and compare whenever the DUT signals done
    always @(negedge clk) begin
        if (!rst && done) begin
            result_t e;
            doneCount++;
            if (prevDone) checkOutput("done_back_to_back", 1, 0);
            if (expQueue.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                e = expQueue.pop_front();
                checkOutput("quotient", 32'(quotient), 32'(e.q));
                checkOutput("remainder", 32'(remainder), 32'(e.r));
                checkOutput("div_by_zero", 32'(div_by_zero), 32'(e.dz));
            end
        end
        prevDone <= done;
    end

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_timeout", 1, 0);
    endtask

    task automatic acceptStart(input logic [N-1:0] a, input logic [N-1:0] b);
        waitIdle();
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done, and busy cycles
    task automatic waitDone(output int edges, output int busyCycles);
        edges = -1;
        busyCycles = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (busy) busyCycles++;
            if (done) begin
                edges = i - 1;
                break;
            end
        end
    endtask

    // Full divide with latency, busy window and result-hold checks
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        int edges;
        int busyCycles;
        result_t e;
        e = model(a, b);
        expQueue.push_back(e);
        acceptStart(a, b);
        waitDone(edges, busyCycles);
        checkOutput("latency", 32'(edges), N);
        @(negedge clk);
        if (busy) busyCycles++;
        checkOutput("busy_after_done", 32'(busy), 0);
        checkOutput("busy_cycles", 32'(busyCycles), N + 1);
        checkOutput("quotient_hold", 32'(quotient), 32'(e.q));
        checkOutput("remainder_hold", 32'(remainder), 32'(e.r));
    endtask

    initial begin
        int snap;
        int lastDone;
        int cyc;
        int pulses;
        result_t e;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_quotient", 32'(quotient), 0);
        checkOutput("rst_remainder", 32'(remainder), 0);
        checkOutput("rst_div_by_zero", 32'(div_by_zero), 0);
        rst = 1'b0;

        applyStimulus(8'd100, 8'd7);
        applyStimulus(8'd255, 8'd1);
        applyStimulus(8'd200, 8'd255);
        applyStimulus(8'd255, 8'd255);
        applyStimulus(8'd77, 8'd0);
        applyStimulus(8'd9, 8'd3);

        // A second start during RUN, with operands changing, must be ignored
        expQueue.push_back(model(8'd100, 8'd7));
        acceptStart(8'd100, 8'd7);
        snap = doneCount;
        repeat (3) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'd33;
        divisor  = 8'd2;
        waitIdle();
        checkOutput("single_done", 32'(doneCount - snap), 1);

        // Start held high: back-to-back operations every N+2 cycles
        waitIdle();
        e = model(8'd100, 8'd7);
        for (int i = 0; i < 3; i++) expQueue.push_back(e);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        pulses   = 0;
        lastDone = -1;
        cyc      = 0;
        while (pulses < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (lastDone >= 0) checkOutput("issue_interval", 32'(cyc - lastDone), N + 2);
                lastDone = cyc;
                pulses++;
            end
        end
        start = 1'b0;
        checkOutput("held_pulses", 32'(pulses), 3);
        waitIdle();
        checkOutput("scoreboard_empty", 32'(expQueue.size()), 0);

        // Reset in the middle of RUN drops the operation
        acceptStart(8'd100, 8'd7);
        snap = doneCount;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_done", 32'(done), 0);
        checkOutput("midrst_quotient", 32'(quotient), 0);
        checkOutput("midrst_remainder", 32'(remainder), 0);
        checkOutput("midrst_div_by_zero", 32'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("no_done_after_rst", 32'(doneCount - snap), 0);
        checkOutput("idle_after_rst", 32'(busy), 0);

        applyStimulus(8'd60, 8'd8);
        checkOutput("scoreboard_final", 32'(expQueue.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative unsigned restoring divider that sits directly downstream of `add_sub`. It drives `add_sub` in subtract mode (`ctrl = 1`) and consumes its `result`/`cout` to produce one quotient bit per clock. The block gives the datapath an N-bit divide with a start/busy/done handshake. It occupies one `add_sub` instance and a small control FSM.

## Interface
- `N`, default 8: operand, quotient and remainder width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a divide; sampled only in IDLE.
- `dividend`  in  N: unsigned dividend; sampled on the edge that accepts `start`.
- `divisor`  in  N: unsigned divisor; sampled on the same edge.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: one-cycle pulse; results valid.
- `quotient`  out  N: registered quotient; holds its value until the next completion.
- `remainder`  out  N: registered remainder; holds its value until the next completion.
- `div_by_zero`  out  1: registered; set at completion when the captured divisor was 0.

## Operation
- Three states:
  - IDLE: `busy` = 0.
  - RUN: `busy` = 1; holds an iteration counter 0..N-1.
  - DONE: `busy` = 1, `done` = 1.
- IDLE & `start`:
  - Capture the divisor into D.
  - Load working quotient Q ← dividend and partial remainder R ← 0.
  - Clear the counter and go to RUN.
- RUN, each cycle:
  - Form S = {R[N-2:0], Q[N-1]}.
  - `add_sub` computes S − D; `cout` = 1 means no borrow (S ≥ D).
  - If `cout` = 1: R ← `result` and Q ← {Q[N-2:0], 1}.
  - Else: R ← S and Q ← {Q[N-2:0], 0}.
- No N+1-bit remainder is needed: before each shift R < 2^(N-1), so S fits in N bits.
- After iteration N-1, the same edge does all of the following:
  - `quotient` ← final Q and `remainder` ← final R.
  - `div_by_zero` ← (D == 0).
  - State goes to DONE.
- DONE → IDLE unconditionally on the next edge.
- `start` is ignored in RUN and DONE. A `start` held high through DONE is accepted on the first IDLE cycle.
- Divide by zero needs no special path. Every trial subtraction succeeds, so `quotient` = all ones, `remainder` = dividend, `div_by_zero` = 1.
- Changes on `dividend`/`divisor` after acceptance have no effect.
- `rst` at any time, including mid-RUN:
  - Immediately forces IDLE.
  - Clears `busy`, `done`, `quotient`, `remainder`, `div_by_zero`, R, Q, D and the counter.
  - An operation interrupted by reset is lost and produces no `done`.

## Timing
- Reset values: `busy` = 0, `done` = 0, `quotient` = 0, `remainder` = 0, `div_by_zero` = 0, state IDLE.
- Let edge k be the edge that accepts `start`:
  - `busy` is high from after edge k.
  - Iterations complete on edges k+1 … k+N.
  - `done` is high for exactly the cycle between edges k+N and k+N+1.
  - `busy` falls after edge k+N+1.
- Latency from `start` acceptance to `done` is N cycles; issue interval is N+2 cycles minimum.
- `quotient`, `remainder` and `div_by_zero` change only on the completing edge (k+N) or on reset. They are stable while `done` is high and afterwards.
- The `add_sub` path is combinational within a RUN cycle. No extra pipeline stage is allowed.
- `done`, `busy` and all result outputs are driven directly from flops.

## Test plan (N = 8)
- Reset release, then `start` with 100 / 7 → `done` exactly 8 cycles after the accepting edge; `quotient` = 14, `remainder` = 2, `div_by_zero` = 0; `busy` high 9 cycles.
- 255 / 1 → `quotient` = 255, `remainder` = 0. Then 200 / 255 → `quotient` = 0, `remainder` = 200. Then 255 / 255 → `quotient` = 1, `remainder` = 0.
- 77 / 0 → `quotient` = 255, `remainder` = 77, `div_by_zero` = 1. A following 9 / 3 clears `div_by_zero` and gives `quotient` = 3, `remainder` = 0.
- `start` with 100 / 7, then pulse `start` with 50 / 5 during RUN and change the operand inputs → second request ignored; result 14 / 2; exactly one `done`.
- `start` held high continuously with 100 / 7 → `done` pulses every 10 cycles; each pulse reports 14 / 2; `done` is never high in back-to-back cycles.
- Assert `rst` 4 cycles into a 100 / 7 RUN → outputs immediately 0, `busy` = 0, no `done`. After release, 60 / 8 gives `quotient` = 7, `remainder` = 4 with normal latency.
